// File: rtl/fsm_leer_rtc_pkg.sv
// Shared definitions for the RTC time-read controller: FSM encoding,
// phase boundaries inside one bus transaction and the step-to-select map.
package fsm_leer_rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_e;

  // Phase boundaries within one 16-cycle transaction (first cycle of each region).
  localparam int PH_STROBE  = 2;
  localparam int PH_HOLD    = 12;
  localparam int PH_RECOVER = 14;
  localparam int PH_END     = 16;

  localparam logic [3:0] LAST_STEP = 4'd12;
  localparam int         NUM_SEL   = 13;

  // Select bit index for each step; bit index equals step number.
  localparam int SEL_COM_CYT  = 0;
  localparam int SEL_DIR_SEG  = 1;
  localparam int SEL_SEG      = 2;
  localparam int SEL_DIR_MIN  = 3;
  localparam int SEL_MIN      = 4;
  localparam int SEL_DIR_HORA = 5;
  localparam int SEL_HORA     = 6;
  localparam int SEL_DIR_DIA  = 7;
  localparam int SEL_DIA      = 8;
  localparam int SEL_DIR_MES  = 9;
  localparam int SEL_MES      = 10;
  localparam int SEL_DIR_ANIO = 11;
  localparam int SEL_ANIO     = 12;

  // Step 0 (command) and all odd steps (addresses) push RAM data to the RTC.
  function automatic logic is_write_step(logic [3:0] step);
    return (step == 4'd0) || step[0];
  endfunction

  // One-hot RAM select for a step; out-of-range steps select nothing.
  function automatic logic [NUM_SEL-1:0] step_sel(logic [3:0] step);
    logic [NUM_SEL-1:0] sel;
    sel = '0;
    if (step <= LAST_STEP) sel[step] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/fsm_leer_rtc_if.sv
// Control/select lines between the read controller and the external
// RTC bus, tri-state buffers and register RAM.
interface fsm_leer_rtc_if;
  logic do_it_leer;
  logic a_d;
  logic cs;
  logic rd;
  logic wr;
  logic rtc_to_ram;
  logic ram_to_rtc;
  logic dir_ram_com_cyt;
  logic dir_ram_dir_seg, dir_ram_dir_min, dir_ram_dir_hora;
  logic dir_ram_dir_dia, dir_ram_dir_mes, dir_ram_dir_anio;
  logic dir_ram_seg, dir_ram_min, dir_ram_hora;
  logic dir_ram_dia, dir_ram_mes, dir_ram_anio;
  logic w_ram_enable;
  logic r_ram_enable;

  modport master (
    input  do_it_leer,
    output a_d, cs, rd, wr, rtc_to_ram, ram_to_rtc,
    output dir_ram_com_cyt,
    output dir_ram_dir_seg, dir_ram_dir_min, dir_ram_dir_hora,
    output dir_ram_dir_dia, dir_ram_dir_mes, dir_ram_dir_anio,
    output dir_ram_seg, dir_ram_min, dir_ram_hora,
    output dir_ram_dia, dir_ram_mes, dir_ram_anio,
    output w_ram_enable, r_ram_enable
  );

  modport slave (
    output do_it_leer,
    input  a_d, cs, rd, wr, rtc_to_ram, ram_to_rtc,
    input  dir_ram_com_cyt,
    input  dir_ram_dir_seg, dir_ram_dir_min, dir_ram_dir_hora,
    input  dir_ram_dir_dia, dir_ram_dir_mes, dir_ram_dir_anio,
    input  dir_ram_seg, dir_ram_min, dir_ram_hora,
    input  dir_ram_dia, dir_ram_mes, dir_ram_anio,
    input  w_ram_enable, r_ram_enable
  );
endinterface

// File: rtl/fsm_leer_rtc_bus_cycle.sv
// Timing of one 16-cycle RTC bus transaction: phase counter plus the
// cs/strobe/enable windows decoded from it, and a done pulse on the last cycle.
module fsm_leer_rtc_bus_cycle
  import fsm_leer_rtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run_i,
  output logic [3:0] phase_o,
  output logic       cs_n_o,
  output logic       strobe_n_o,
  output logic       en_o,
  output logic       strobe_last_o,
  output logic       done_o
);

  logic [3:0] phase_q, phase_d;

  // Count through the transaction while running; wraps 15 -> 0 into the next step.
  always_comb begin
    phase_d = '0;
    if (run_i) phase_d = phase_q + 4'd1;
  end

  // Phase register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  assign phase_o       = phase_q;
  assign en_o          = run_i && (phase_q < 4'(PH_RECOVER));
  assign cs_n_o        = !en_o;
  assign strobe_n_o    = !(run_i && (phase_q >= 4'(PH_STROBE)) && (phase_q < 4'(PH_HOLD)));
  assign strobe_last_o = run_i && (phase_q == 4'(PH_HOLD - 1));
  assign done_o        = run_i && (phase_q == 4'(PH_END - 1));

endmodule

// File: rtl/fsm_leer_rtc.sv
// Reads seconds..year from a multiplexed address/data RTC into register RAM:
// one command write followed by six address-write / data-read pairs.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | bus released, waiting for do_it_leer
// ST_SETUP   | cs low, select/direction valid, strobe high
// ST_STROBE  | rd or wr low for 10 cycles
// ST_HOLD    | strobe high, cs/select/enables held
// ST_RECOVER | cs high, bus enables off, select still valid
module fsm_leer_rtc
  import fsm_leer_rtc_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fsm_leer_rtc_if.master bus
);

  state_e             state_q, state_d;
  logic [3:0]         step_q, step_d;
  logic               run;
  logic [3:0]         phase;
  logic               cs_n, strobe_n, en, strobe_last, done;
  logic               wr_step;
  logic [NUM_SEL-1:0] sel;

  assign run = (state_q != ST_IDLE);

  fsm_leer_rtc_bus_cycle u_bus_cycle (
    .clk          (clk),
    .reset        (reset),
    .run_i        (run),
    .phase_o      (phase),
    .cs_n_o       (cs_n),
    .strobe_n_o   (strobe_n),
    .en_o         (en),
    .strobe_last_o(strobe_last),
    .done_o       (done)
  );

  // State and step registers, forced to idle/step 0 asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next state follows the phase counter; outputs decoded from registered state only.
  always_comb begin
    state_d          = state_q;
    step_d           = step_q;
    wr_step          = is_write_step(step_q);
    sel              = '0;
    bus.a_d          = 1'b1;
    bus.cs           = 1'b1;
    bus.rd           = 1'b1;
    bus.wr           = 1'b1;
    bus.rtc_to_ram   = 1'b0;
    bus.ram_to_rtc   = 1'b0;
    bus.w_ram_enable = 1'b0;
    bus.r_ram_enable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.do_it_leer) begin
          state_d = ST_SETUP;
          step_d  = '0;
        end
      end
      ST_SETUP:  if (phase == 4'(PH_STROBE - 1))  state_d = ST_STROBE;
      ST_STROBE: if (phase == 4'(PH_HOLD - 1))    state_d = ST_HOLD;
      ST_HOLD:   if (phase == 4'(PH_RECOVER - 1)) state_d = ST_RECOVER;
      ST_RECOVER: begin
        if (done) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_IDLE;
            step_d  = '0;
          end else begin
            state_d = ST_SETUP;
            step_d  = step_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase

    if (run) begin
      sel              = step_sel(step_q);
      bus.a_d          = !wr_step;
      bus.cs           = cs_n;
      bus.wr           = wr_step ? strobe_n : 1'b1;
      bus.rd           = wr_step ? 1'b1 : strobe_n;
      bus.ram_to_rtc   = en && wr_step;
      bus.r_ram_enable = en && wr_step;
      bus.rtc_to_ram   = en && !wr_step;
      // RAM captures on the last rd-low cycle, when RTC data is settled.
      bus.w_ram_enable = strobe_last && !wr_step;
    end
  end

  assign bus.dir_ram_com_cyt  = sel[SEL_COM_CYT];
  assign bus.dir_ram_dir_seg  = sel[SEL_DIR_SEG];
  assign bus.dir_ram_seg      = sel[SEL_SEG];
  assign bus.dir_ram_dir_min  = sel[SEL_DIR_MIN];
  assign bus.dir_ram_min      = sel[SEL_MIN];
  assign bus.dir_ram_dir_hora = sel[SEL_DIR_HORA];
  assign bus.dir_ram_hora     = sel[SEL_HORA];
  assign bus.dir_ram_dir_dia  = sel[SEL_DIR_DIA];
  assign bus.dir_ram_dia      = sel[SEL_DIA];
  assign bus.dir_ram_dir_mes  = sel[SEL_DIR_MES];
  assign bus.dir_ram_mes      = sel[SEL_MES];
  assign bus.dir_ram_dir_anio = sel[SEL_DIR_ANIO];
  assign bus.dir_ram_anio     = sel[SEL_ANIO];

endmodule

// File: tb/tb_fsm_leer_rtc.sv
// Bench for the RTC time-read controller. Expected per-cycle output vectors
// are queued when a read is launched and popped at each falling edge.
module tb_fsm_leer_rtc;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fsm_leer_rtc_if bus();

  fsm_leer_rtc dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // [20]a_d [19]cs [18]rd [17]wr [16]rtc_to_ram [15]ram_to_rtc [14:2]selects (bit = step) [1]w [0]r
  typedef logic [20:0] vec_t;
  localparam vec_t IDLE_V = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 13'b0, 1'b0, 1'b0};

  int   n_vec = 0;
  int   n_err = 0;
  vec_t sb[$];

  function automatic vec_t exp_vec(int step, int ph);
    logic wrt, en, strb;
    logic [12:0] sel;
    wrt  = (step == 0) || (step % 2 == 1);
    en   = (ph < 14);
    strb = (ph >= 2) && (ph <= 11);
    sel  = 13'b1 << step;
    return {~wrt, ~en, ~(~wrt & strb), ~(wrt & strb), ~wrt & en, wrt & en,
            sel, ~wrt & (ph == 11), wrt & en};
  endfunction

  function automatic vec_t obs();
    return {bus.a_d, bus.cs, bus.rd, bus.wr, bus.rtc_to_ram, bus.ram_to_rtc,
            bus.dir_ram_anio, bus.dir_ram_dir_anio, bus.dir_ram_mes, bus.dir_ram_dir_mes,
            bus.dir_ram_dia, bus.dir_ram_dir_dia, bus.dir_ram_hora, bus.dir_ram_dir_hora,
            bus.dir_ram_min, bus.dir_ram_dir_min, bus.dir_ram_seg, bus.dir_ram_dir_seg,
            bus.dir_ram_com_cyt, bus.w_ram_enable, bus.r_ram_enable};
  endfunction

  task automatic test_reset();
    vec_t got;
    reset = 1'b1;
    bus.do_it_leer = 1'b1;
    repeat (9) begin
      @(negedge clk);
      got = obs();
      n_vec++;
      if (got !== IDLE_V) begin
        n_err++;
        $display("FAIL reset_idle t=%0t: got %h want %h", $time, got, IDLE_V);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_run();
    vec_t exp, got;
    int idx = 0;
    int w_cnt = 0, wr_low0 = 0, rd_low0 = 0, rd_low2 = 0;
    int last_rd2 = -1, w_idx2 = -1, onehot_bad = 0, prev = -1, cur;
    int order[$];
    for (int s = 0; s < 13; s++)
      for (int p = 0; p < 16; p++) sb.push_back(exp_vec(s, p));
    repeat (17) sb.push_back(IDLE_V);
    while (sb.size() > 0) begin
      @(negedge clk);
      if (idx == 2) bus.do_it_leer = 1'b0;
      exp = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL full_run cycle %0d: got %h want %h", idx, got, exp);
      end
      if (got[1]) w_cnt++;
      if (idx < 16 && !got[17]) wr_low0++;
      if (idx < 16 && !got[18]) rd_low0++;
      if (idx >= 32 && idx < 48 && !got[18]) begin
        rd_low2++;
        last_rd2 = idx;
      end
      if (idx >= 32 && idx < 48 && got[1]) w_idx2 = idx;
      if (idx < 208) begin
        if ($countones(got[14:2]) != 1) onehot_bad++;
        else begin
          cur = 0;
          for (int b = 0; b < 13; b++) if (got[2+b]) cur = b;
          if (cur != prev) begin
            order.push_back(cur);
            prev = cur;
          end
        end
      end
      idx++;
    end
    n_vec++;
    if (w_cnt !== 6) begin
      n_err++;
      $display("FAIL w_pulse_count: got %0d want 6", w_cnt);
    end
    n_vec++;
    if (wr_low0 !== 10) begin
      n_err++;
      $display("FAIL step0_wr_low: got %0d want 10", wr_low0);
    end
    n_vec++;
    if (rd_low0 !== 0) begin
      n_err++;
      $display("FAIL step0_rd_low: got %0d want 0", rd_low0);
    end
    n_vec++;
    if (rd_low2 !== 10) begin
      n_err++;
      $display("FAIL step2_rd_low: got %0d want 10", rd_low2);
    end
    n_vec++;
    if (w_idx2 !== 43 || last_rd2 !== 43) begin
      n_err++;
      $display("FAIL step2_w_align: w at %0d last rd-low at %0d want both 43", w_idx2, last_rd2);
    end
    n_vec++;
    if (onehot_bad !== 0) begin
      n_err++;
      $display("FAIL select_onehot: got %0d bad cycles want 0", onehot_bad);
    end
    n_vec++;
    if (order.size() !== 13) begin
      n_err++;
      $display("FAIL select_order_len: got %0d want 13", order.size());
    end else begin
      for (int i = 0; i < 13; i++) begin
        n_vec++;
        if (order[i] !== i) begin
          n_err++;
          $display("FAIL select_order[%0d]: got %0d want %0d", i, order[i], i);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t exp, got;
    int idx = 0;
    bus.do_it_leer = 1'b1;
    for (int s = 0; s < 13; s++)
      for (int p = 0; p < 16; p++) sb.push_back(exp_vec(s, p));
    sb.push_back(IDLE_V);
    for (int s = 0; s < 13; s++)
      for (int p = 0; p < 16; p++) sb.push_back(exp_vec(s, p));
    repeat (3) sb.push_back(IDLE_V);
    while (sb.size() > 0) begin
      @(negedge clk);
      if (idx == 211) bus.do_it_leer = 1'b0;
      exp = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL back_to_back cycle %0d: got %h want %h", idx, got, exp);
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    vec_t exp, got;
    int idx = 0;
    bus.do_it_leer = 1'b1;
    for (int c = 0; c < 85; c++) sb.push_back(exp_vec(c / 16, c % 16));
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL pre_reset cycle %0d: got %h want %h", idx, got, exp);
      end
      idx++;
    end
    @(posedge clk);
    #1;
    got = obs();
    n_vec++;
    if (got !== exp_vec(5, 5)) begin
      n_err++;
      $display("FAIL step5_strobe: got %h want %h", got, exp_vec(5, 5));
    end
    #1 reset = 1'b1;
    #1;
    got = obs();
    n_vec++;
    if (got !== IDLE_V) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", got, IDLE_V);
    end
    repeat (3) begin
      @(negedge clk);
      got = obs();
      n_vec++;
      if (got !== IDLE_V) begin
        n_err++;
        $display("FAIL reset_hold: got %h want %h", got, IDLE_V);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    idx = 0;
    for (int c = 0; c < 32; c++) sb.push_back(exp_vec(c / 16, c % 16));
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front();
      got = obs();
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL restart cycle %0d: got %h want %h", idx, got, exp);
      end
      idx++;
    end
    bus.do_it_leer = 1'b0;
  endtask

  initial begin
    bus.do_it_leer = 1'b1;
    test_reset();
    test_full_run();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
